// File: rtl/sec_b2a_pkg.sv
// sec_b2a_pkg: shared state encoding and sizing helpers for the serial Boolean-to-arithmetic converter
package sec_b2a_pkg;
    typedef enum logic [2:0] {IDLE, ADD, REFRESH, FOLD, DONE} state_e;
    function automatic int rand_and_bits(input int n);
        return n * (n - 1);
    endfunction
    function automatic int share_lo(input int i, input int k);
        return i * k;
    endfunction
    function automatic bit shares_ok(input int n);
        return n >= 2;
    endfunction
endpackage

// File: rtl/sec_b2a_serial_and.sv
// sec_and_isw_bit: 1-bit N-share ISW multiplication using N(N-1)/2 fresh random bits
module sec_and_isw_bit #(
    parameter int N = 2
) (
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    input  logic [N*(N-1)/2-1:0] r,
    output logic [N-1:0]         c
);
    always_comb begin
        int k;
        k = 0;
        c = a & b;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++) begin
                c[i] = c[i] ^ r[k];
                c[j] = c[j] ^ ((r[k] ^ (a[i] & b[j])) ^ (a[j] & b[i]));
                k++;
            end
    end
endmodule

// File: rtl/sec_b2a_serial.sv
// sec_b2a_serial: bit-serial masked ripple adder converting N Boolean shares into N arithmetic shares mod 2^K
module sec_b2a_serial
    import sec_b2a_pkg::*;
#(
    parameter int K_WIDTH   = 32,
    parameter int N_SHARES  = 8,
    parameter int MASKWIDTH = K_WIDTH * N_SHARES,
    parameter int RAND_AND  = rand_and_bits(N_SHARES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_dvld,
    output logic                            o_drdy,
    input  logic [MASKWIDTH-1:0]            i_b,
    input  logic [(N_SHARES-1)*K_WIDTH-1:0] i_rnd_a,
    input  logic                            i_rvld,
    input  logic [RAND_AND-1:0]             i_rnd_and,
    input  logic [(N_SHARES-1)*K_WIDTH-1:0] i_rnd_ref,
    output logic [MASKWIDTH-1:0]            o_a,
    output logic                            o_dvld,
    input  logic                            i_drdy
);
    localparam int CW = $clog2(N_SHARES);
    localparam int BW = K_WIDTH > 1 ? $clog2(K_WIDTH) : 1;
    localparam int H  = N_SHARES * (N_SHARES - 1) / 2;

    if (!shares_ok(N_SHARES)) begin : g_bad_shares
        $error("sec_b2a_serial: N_SHARES must be >= 2");
    end

    state_e                            state_q, state_d;
    logic [MASKWIDTH-1:0]              s_q, s_d;
    logic [(N_SHARES-1)*K_WIDTH-1:0]   a_r_q, a_r_d;
    logic [K_WIDTH-1:0]                a_last_q, a_last_d, neg_aj, rsum, fold;
    logic [N_SHARES-1:0]               carry_q, carry_d, xb, yb, and_xy, and_cp;
    logic [CW-1:0]                     add_cnt_q, add_cnt_d;
    logic [BW-1:0]                     bit_cnt_q, bit_cnt_d;
    logic                              last_bit;

    assign last_bit = bit_cnt_q == BW'(K_WIDTH - 1);
    assign o_drdy   = state_q == IDLE;
    assign o_dvld   = state_q == DONE;
    assign o_a      = {a_last_q, a_r_q};

    // Operand Y of iteration j is (-A_j, 0, ..., 0); S shifts right so its LSB is always bit t
    always_comb begin
        neg_aj = ~a_r_q[add_cnt_q*K_WIDTH +: K_WIDTH] + 1'b1;
        yb     = '0;
        yb[0]  = neg_aj[bit_cnt_q];
        for (int i = 0; i < N_SHARES; i++)
            xb[i] = s_q[share_lo(i, K_WIDTH)];
    end

    sec_and_isw_bit #(.N(N_SHARES)) u_and_xy (
        .a(xb), .b(yb), .r(i_rnd_and[H-1:0]), .c(and_xy)
    );
    sec_and_isw_bit #(.N(N_SHARES)) u_and_cp (
        .a(carry_q), .b(xb ^ yb), .r(i_rnd_and[2*H-1:H]), .c(and_cp)
    );

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        a_r_d     = a_r_q;
        a_last_d  = a_last_q;
        carry_d   = carry_q;
        add_cnt_d = add_cnt_q;
        bit_cnt_d = bit_cnt_q;
        rsum      = '0;
        fold      = '0;
        for (int i = 0; i < N_SHARES - 1; i++)
            rsum = rsum ^ i_rnd_ref[share_lo(i, K_WIDTH) +: K_WIDTH];
        for (int i = 0; i < N_SHARES; i++)
            fold = fold ^ s_q[share_lo(i, K_WIDTH) +: K_WIDTH];
        case (state_q)
            IDLE: if (i_dvld) begin
                state_d   = ADD;
                s_d       = i_b;
                a_r_d     = i_rnd_a;
                carry_d   = '0;
                add_cnt_d = '0;
                bit_cnt_d = '0;
            end
            ADD: if (i_rvld) begin
                for (int i = 0; i < N_SHARES; i++)
                    s_d[share_lo(i, K_WIDTH) +: K_WIDTH] = (s_q[share_lo(i, K_WIDTH) +: K_WIDTH] >> 1)
                        | (K_WIDTH'(xb[i] ^ yb[i] ^ carry_q[i]) << (K_WIDTH - 1));
                // Carry out of the MSB is dropped, which makes the sum mod 2^K
                carry_d   = last_bit ? '0 : and_xy ^ and_cp;
                bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
                add_cnt_d = last_bit ? add_cnt_q + 1'b1 : add_cnt_q;
                state_d   = last_bit && add_cnt_q == CW'(N_SHARES - 2) ? REFRESH : ADD;
            end
            REFRESH: if (i_rvld) begin
                s_d     = s_q ^ {rsum, i_rnd_ref};
                state_d = FOLD;
            end
            FOLD: begin
                a_last_d = fold;
                state_d  = DONE;
            end
            DONE: state_d = i_drdy ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s_q       <= '0;
            a_r_q     <= '0;
            a_last_q  <= '0;
            carry_q   <= '0;
            add_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            a_r_q     <= a_r_d;
            a_last_q  <= a_last_d;
            carry_q   <= carry_d;
            add_cnt_q <= add_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end
endmodule

// File: tb/tb_sec_b2a_serial.sv
// tb_sec_b2a_serial: directed and random scoreboard bench over N=2/K=8, N=3/K=8 and N=8/K=32 instances
module tb_sec_b2a_serial;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   dvi = '0;
    logic [2:0]   dvo, rdyo;
    logic         rvld = 1'b1;
    logic         drdy = 1'b1;
    logic [255:0] ib = '0;
    logic [223:0] rnd_a = '0;
    logic [223:0] rnd_ref = '0;
    logic [55:0]  rnd_and = '0;
    logic [15:0]  oa2;
    logic [23:0]  oa3;
    logic [255:0] oa8;
    logic [255:0] expq [$];
    logic [255:0] rb [80];
    logic [223:0] ra [80];
    int           nvec = 0;
    int           nfail = 0;

    always #5 clk = ~clk;

    sec_b2a_serial #(.K_WIDTH(8), .N_SHARES(2)) u_n2 (
        .clk(clk), .rst(rst), .i_dvld(dvi[0]), .o_drdy(rdyo[0]), .i_b(ib[15:0]),
        .i_rnd_a(rnd_a[7:0]), .i_rvld(rvld), .i_rnd_and(rnd_and[1:0]), .i_rnd_ref(rnd_ref[7:0]),
        .o_a(oa2), .o_dvld(dvo[0]), .i_drdy(drdy)
    );
    sec_b2a_serial #(.K_WIDTH(8), .N_SHARES(3)) u_n3 (
        .clk(clk), .rst(rst), .i_dvld(dvi[1]), .o_drdy(rdyo[1]), .i_b(ib[23:0]),
        .i_rnd_a(rnd_a[15:0]), .i_rvld(rvld), .i_rnd_and(rnd_and[5:0]), .i_rnd_ref(rnd_ref[15:0]),
        .o_a(oa3), .o_dvld(dvo[1]), .i_drdy(drdy)
    );
    sec_b2a_serial u_n8 (
        .clk(clk), .rst(rst), .i_dvld(dvi[2]), .o_drdy(rdyo[2]), .i_b(ib),
        .i_rnd_a(rnd_a), .i_rvld(rvld), .i_rnd_and(rnd_and), .i_rnd_ref(rnd_ref),
        .o_a(oa8), .o_dvld(dvo[2]), .i_drdy(drdy)
    );

    function automatic logic [255:0] oa_of(input int sel);
        return sel == 0 ? {240'b0, oa2} : sel == 1 ? {232'b0, oa3} : oa8;
    endfunction

    // Expected shares: A_r passes through, A_last = XOR(i_b shares) - sum(A_r) mod 2^K
    function automatic logic [255:0] model(input int n, input int k, input logic [255:0] b, input logic [223:0] a);
        logic [255:0] m, x, s, ae;
        m  = (256'd1 << k) - 1;
        ae = {32'b0, a};
        x  = '0;
        s  = '0;
        for (int i = 0; i < n; i++) x = x ^ ((b >> (i * k)) & m);
        for (int i = 0; i < n - 1; i++) s = s + ((ae >> (i * k)) & m);
        return (ae & ((256'd1 << ((n - 1) * k)) - 1)) | (((x - s) & m) << ((n - 1) * k));
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic convert(input int sel, input int n, input int k, input logic [255:0] b,
                           input logic [223:0] a, input bit zr, input bit stall, input bit hold, input string tag);
        int           lat, base;
        logic [255:0] got;
        base = (n - 1) * k + 2;
        @(negedge clk);
        chk({tag, " drdy_idle"}, {255'b0, rdyo[sel]}, 256'd1);
        ib       = b;
        rnd_a    = a;
        dvi[sel] = 1'b1;
        drdy     = !hold;
        expq.push_back(model(n, k, b, a));
        @(posedge clk);
        @(negedge clk);
        dvi[sel] = 1'b0;
        lat = 0;
        while (!dvo[sel] && lat < 4000) begin
            rvld    = !(stall && ((lat >= 3 && lat < 8) || lat == base + 3));
            rnd_and = zr ? '0 : 56'({$urandom, $urandom});
            for (int w = 0; w < 7; w++) rnd_ref[w*32 +: 32] = zr ? 32'd0 : $urandom;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rvld = 1'b1;
        chk({tag, " latency"}, 256'(lat), 256'(base + (stall ? 6 : 0)));
        got = oa_of(sel);
        chk({tag, " o_a"}, got, expq.pop_front());
        if (hold) begin
            repeat (4) begin
                @(posedge clk);
                @(negedge clk);
                chk({tag, " hold o_a"}, oa_of(sel), got);
                chk({tag, " hold o_dvld"}, {255'b0, dvo[sel]}, 256'd1);
                chk({tag, " hold o_drdy"}, {255'b0, rdyo[sel]}, 256'd0);
            end
            drdy = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, " release o_dvld"}, {255'b0, dvo[sel]}, 256'd0);
        chk({tag, " release o_drdy"}, {255'b0, rdyo[sel]}, 256'd1);
    endtask

    initial begin
        @(negedge clk);
        chk("reset o_a n2", {240'b0, oa2}, 256'd0);
        chk("reset o_a n3", {232'b0, oa3}, 256'd0);
        chk("reset o_a n8", oa8, 256'd0);
        chk("reset o_dvld", {253'b0, dvo}, 256'd0);
        chk("reset o_drdy", {253'b0, rdyo}, 256'd7);
        rst = 1'b0;

        convert(0, 2, 8, 256'h0000_AA3C, 224'h10, 1'b0, 1'b0, 1'b0, "n2_x96");
        convert(0, 2, 8, 256'h0000_0F0A, 224'hFF, 1'b0, 1'b0, 1'b0, "n2_wrap");
        chk("n2_wrap const", model(2, 8, 256'h0F0A, 224'hFF), 256'h06FF);
        convert(1, 3, 8, 256'h005A_3369, 224'h0201, 1'b0, 1'b0, 1'b0, "n3_zero");
        chk("n3_zero const", model(3, 8, 256'h5A3369, 224'h0201), 256'hFD0201);
        convert(0, 2, 8, 256'h0000_AA3C, 224'h10, 1'b0, 1'b1, 1'b1, "n2_stall_hold");

        @(negedge clk);
        ib     = 256'h1234;
        rnd_a  = 224'h55;
        dvi[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dvi[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort o_dvld", {255'b0, dvo[0]}, 256'd0);
        chk("abort o_drdy", {255'b0, rdyo[0]}, 256'd1);
        chk("abort o_a", {240'b0, oa2}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        convert(0, 2, 8, 256'h0000_C3F0, 224'h7E, 1'b0, 1'b0, 1'b0, "n2_post_reset");

        for (int t = 0; t < 80; t++) begin
            for (int w = 0; w < 8; w++) rb[t][w*32 +: 32] = $urandom;
            for (int w = 0; w < 7; w++) ra[t][w*32 +: 32] = $urandom;
            convert(2, 8, 32, rb[t], ra[t], 1'b0, 1'b0, 1'b0, "n8_rand");
        end
        for (int t = 0; t < 80; t++)
            convert(2, 8, 32, rb[t], ra[t], 1'b1, 1'b0, 1'b0, "n8_zero_rnd");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
